// File: rtl/if_id_decode_if.sv
// IF/ID decode bundle: fetch inputs, writeback port,
// and the decoded control/data outputs.
interface if_id_decode_if;
  logic [31:0] instruction;
  logic [31:0] PCplus4;
  logic        stall;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  logic        PCSrc;
  logic [31:0] PCSrc_immediate;
  logic        Jump;
  logic [25:0] Jump_immediate;
  logic        id_valid;
  logic [31:0] id_PCplus4;

  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] imm_ext;
  logic [4:0]  dest;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        alu_src;
  logic [5:0]  funct;

  modport master (
    output instruction, PCplus4, stall,
    output wb_en, wb_addr, wb_data,
    input  PCSrc, PCSrc_immediate, Jump,
    input  Jump_immediate, id_valid, id_PCplus4,
    input  rs_data, rt_data, imm_ext, dest,
    input  reg_write, mem_read, mem_write,
    input  alu_src, funct
  );

  modport slave (
    input  instruction, PCplus4, stall,
    input  wb_en, wb_addr, wb_data,
    output PCSrc, PCSrc_immediate, Jump,
    output Jump_immediate, id_valid, id_PCplus4,
    output rs_data, rt_data, imm_ext, dest,
    output reg_write, mem_read, mem_write,
    output alu_src, funct
  );
endinterface

// File: rtl/if_id_decode.sv
// IF/ID pipeline register with decode, register file,
// writeback forwarding and early branch/jump resolution.
module if_id_decode (
  input logic           CLK,
  input logic           RST,
  if_id_decode_if.slave bus
);

  logic [31:0] ir;
  logic [31:0] pc4;
  logic        valid;
  logic [31:0] rf [32];

  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm;
  logic [31:0] imm_ext;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        wb_hit;
  logic        squash;

  logic is_r, is_lw, is_sw, is_beq;
  logic is_bne, is_addi, is_j;

  assign op  = ir[31:26];
  assign rs  = ir[25:21];
  assign rt  = ir[20:16];
  assign rd  = ir[15:11];
  assign imm = ir[15:0];

  assign imm_ext = {{16{imm[15]}}, imm};

  assign wb_hit = bus.wb_en && (bus.wb_addr != 5'd0);

  assign rs_val = (wb_hit && bus.wb_addr == rs)
                ? bus.wb_data : rf[rs];
  assign rt_val = (wb_hit && bus.wb_addr == rt)
                ? bus.wb_data : rf[rt];

  // One-hot opcode classification; unknown opcodes stay all-zero
  always_comb begin
    is_r    = 1'b0;
    is_lw   = 1'b0;
    is_sw   = 1'b0;
    is_beq  = 1'b0;
    is_bne  = 1'b0;
    is_addi = 1'b0;
    is_j    = 1'b0;
    unique case (op)
      6'h00:   is_r    = 1'b1;
      6'h23:   is_lw   = 1'b1;
      6'h2B:   is_sw   = 1'b1;
      6'h04:   is_beq  = 1'b1;
      6'h05:   is_bne  = 1'b1;
      6'h08:   is_addi = 1'b1;
      6'h02:   is_j    = 1'b1;
      default: ;
    endcase
  end

  assign bus.PCSrc = valid && !bus.stall &&
    ((is_beq && rs_val == rt_val) ||
     (is_bne && rs_val != rt_val));
  assign bus.Jump = valid && is_j && !bus.stall;

  assign bus.PCSrc_immediate = {imm_ext[29:0], 2'b00};
  assign bus.Jump_immediate  = ir[25:0];
  assign bus.id_valid        = valid;
  assign bus.id_PCplus4      = pc4;
  assign bus.rs_data         = rs_val;
  assign bus.rt_data         = rt_val;
  assign bus.imm_ext         = imm_ext;
  assign bus.dest            = is_r ? rd : rt;
  assign bus.funct           = ir[5:0];

  assign bus.reg_write = valid && (is_r || is_lw || is_addi);
  assign bus.mem_read  = valid && is_lw;
  assign bus.mem_write = valid && is_sw;
  assign bus.alu_src   = valid && (is_lw || is_sw || is_addi);

  // A resolved branch/jump replaces the next fetch with a bubble
  assign squash = bus.PCSrc || bus.Jump;

  // IF/ID register: stall holds, squash bubbles, else load
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ir    <= '0;
      pc4   <= '0;
      valid <= 1'b0;
    end else if (bus.stall) begin
      ir    <= ir;
      pc4   <= pc4;
      valid <= valid;
    end else if (squash) begin
      ir    <= '0;
      pc4   <= '0;
      valid <= 1'b0;
    end else begin
      ir    <= bus.instruction;
      pc4   <= bus.PCplus4;
      valid <= 1'b1;
    end
  end

  // Register file write port; r0 is never written
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (wb_hit) begin
      rf[bus.wb_addr] <= bus.wb_data;
    end
  end

endmodule
